// File: rtl/lut_pattern_sequencer.sv
// Steps a 4-input LUT's 16-bit truth table through a programmable pattern list.
// Each advance event delivers the next pattern over the LUT's enable/update handshake.
module lut_pattern_sequencer #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          rstn_i,
   input  logic          wr_en_i,
   input  logic [AW-1:0] wr_addr_i,
   input  logic [15:0]   wr_data_i,
   input  logic [AW-1:0] cfg_len_i,
   input  logic          cfg_loop_i,
   input  logic          start_i,
   input  logic          stop_i,
   input  logic          event_i,
   output logic          lut_en_o,
   output logic          lut_update_o,
   output logic [15:0]   lut_cfg_o,
   output logic [AW-1:0] idx_o,
   output logic          busy_o,
   output logic          done_o
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state_q, state_d;
   logic [15:0]   mem_q [DEPTH];
   logic [AW-1:0] len_q, len_d;
   logic          loop_q, loop_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [15:0]   cfg_q, cfg_d;
   logic          en_q, en_d;
   logic          upd_q, upd_d;
   logic          busy_q;
   logic          done_q, done_d;
   logic [AW-1:0] rd_addr;
   logic [15:0]   rd_data;

   // NOTE: the pattern file is cleared by reset, so it cannot map onto a reset-less RAM macro.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   // A same-cycle write to the entry being loaded wins over the stored value.
   always_comb begin
      rd_data = mem_q[rd_addr];
      if (wr_en_i && (wr_addr_i == rd_addr)) rd_data = wr_data_i;
   end

   // NOTE: every signal assigned here gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      loop_d  = loop_q;
      idx_d   = idx_q;
      cfg_d   = cfg_q;
      en_d    = en_q;
      upd_d   = 1'b0;
      done_d  = 1'b0;
      rd_addr = '0;

      if (stop_i) begin
         state_d = IDLE;
         en_d    = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start_i) begin
                  len_d   = cfg_len_i;
                  loop_d  = cfg_loop_i;
                  idx_d   = '0;
                  cfg_d   = rd_data;
                  en_d    = 1'b1;
                  state_d = RUN;
               end
            end
            RUN: begin
               if (event_i) begin
                  if (idx_q < len_q) begin
                     rd_addr = idx_q + AW'(1);
                     idx_d   = rd_addr;
                     cfg_d   = rd_data;
                     upd_d   = 1'b1;
                  end else if (loop_q) begin
                     idx_d = '0;
                     cfg_d = rd_data;
                     upd_d = 1'b1;
                  end else begin
                     done_d  = 1'b1;
                     state_d = DONE;
                  end
               end
            end
            DONE: begin
               // Enable is already high here, so the LUT needs an explicit update pulse.
               if (start_i) begin
                  len_d   = cfg_len_i;
                  loop_d  = cfg_loop_i;
                  idx_d   = '0;
                  cfg_d   = rd_data;
                  upd_d   = 1'b1;
                  state_d = RUN;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q <= IDLE;
         len_q   <= '0;
         loop_q  <= 1'b0;
         idx_q   <= '0;
         cfg_q   <= '0;
         en_q    <= 1'b0;
         upd_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         loop_q  <= loop_d;
         idx_q   <= idx_d;
         cfg_q   <= cfg_d;
         en_q    <= en_d;
         upd_q   <= upd_d;
         busy_q  <= (state_d == RUN);
         done_q  <= done_d;
      end
   end

   assign lut_en_o     = en_q;
   assign lut_update_o = upd_q;
   assign lut_cfg_o    = cfg_q;
   assign idx_o        = idx_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;

endmodule

// File: tb/tb_lut_pattern_sequencer.sv
// Self-checking bench for lut_pattern_sequencer: directed scenarios followed by
// random traffic, all compared against a behavioural model of the pattern sequence.
module tb_lut_pattern_sequencer;

   localparam int DEPTH = 8;
   localparam int AW    = 3;

   logic          clk = 1'b0;
   logic          rstn_i = 1'b0;
   logic          wr_en_i = 1'b0;
   logic [AW-1:0] wr_addr_i = '0;
   logic [15:0]   wr_data_i = '0;
   logic [AW-1:0] cfg_len_i = '0;
   logic          cfg_loop_i = 1'b0;
   logic          start_i = 1'b0;
   logic          stop_i = 1'b0;
   logic          event_i = 1'b0;
   logic          lut_en_o, lut_update_o, busy_o, done_o;
   logic [15:0]   lut_cfg_o;
   logic [AW-1:0] idx_o;

   lut_pattern_sequencer #(.DEPTH(DEPTH)) dut (
      .clk_i(clk), .rstn_i(rstn_i),
      .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
      .cfg_len_i(cfg_len_i), .cfg_loop_i(cfg_loop_i),
      .start_i(start_i), .stop_i(stop_i), .event_i(event_i),
      .lut_en_o(lut_en_o), .lut_update_o(lut_update_o), .lut_cfg_o(lut_cfg_o),
      .idx_o(idx_o), .busy_o(busy_o), .done_o(done_o)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference model: the sequence as a list position plus running/finished flags.
   logic [15:0] m_mem [DEPTH];
   int          m_pos, m_last;
   bit          m_loop, m_running, m_finished;
   logic [15:0] e_cfg;
   bit          e_en, e_upd, e_done;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] fetch(input int a);
      if (wr_en_i && int'(wr_addr_i) == a) return wr_data_i;
      return m_mem[a];
   endfunction

   task automatic model();
      if (!rstn_i) begin
         for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
         m_pos = 0; m_last = 0; m_loop = 0; m_running = 0; m_finished = 0;
         e_cfg = '0; e_en = 0; e_upd = 0; e_done = 0;
         return;
      end
      e_upd  = 0;
      e_done = 0;
      if (stop_i) begin
         m_running = 0; m_finished = 0; e_en = 0;
      end else if (start_i && !m_running) begin
         e_upd  = m_finished;   // a restart from DONE must re-trigger the LUT
         m_last = int'(cfg_len_i); m_loop = cfg_loop_i;
         m_pos  = 0; e_cfg = fetch(0); e_en = 1;
         m_running = 1; m_finished = 0;
      end else if (event_i && m_running) begin
         if (m_pos != m_last || m_loop) begin
            m_pos = (m_pos == m_last) ? 0 : m_pos + 1;
            e_cfg = fetch(m_pos);
            e_upd = 1;
         end else begin
            e_done = 1; m_running = 0; m_finished = 1;
         end
      end
      if (wr_en_i) m_mem[wr_addr_i] = wr_data_i;
   endtask

   // One clock: model consumes the driven inputs, outputs sampled 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      model();
      #1;
      check("lut_en",     16'(lut_en_o),     16'(e_en));
      check("lut_update", 16'(lut_update_o), 16'(e_upd));
      check("lut_cfg",    lut_cfg_o,         e_cfg);
      check("idx",        16'(idx_o),        16'(m_pos));
      check("busy",       16'(busy_o),       16'(m_running));
      check("done",       16'(done_o),       16'(e_done));
      rstn_i = 1'b1; wr_en_i = 1'b0; start_i = 1'b0; stop_i = 1'b0; event_i = 1'b0;
   endtask

   task automatic wr(input int a, input logic [15:0] d);
      wr_en_i = 1'b1; wr_addr_i = AW'(a); wr_data_i = d;
   endtask

   initial begin
      // Reset state
      rstn_i = 1'b0;
      tick();
      check("reset_cfg", lut_cfg_o, 16'h0000);

      // One-shot sequence of four patterns
      wr(0, 16'h8000); tick();
      wr(1, 16'h00FF); tick();
      wr(2, 16'hF0F0); tick();
      wr(3, 16'h6996); tick();
      cfg_len_i = 3'd3; cfg_loop_i = 1'b0; start_i = 1'b1; tick();
      check("start_cfg", lut_cfg_o, 16'h8000);
      check("start_noupd", 16'(lut_update_o), 16'h0);
      event_i = 1'b1; tick();
      check("ev1_cfg", lut_cfg_o, 16'h00FF);
      event_i = 1'b1; tick();
      event_i = 1'b1; tick();
      check("ev3_cfg", lut_cfg_o, 16'h6996);
      event_i = 1'b1; tick();
      check("oneshot_done", 16'(done_o), 16'h1);
      check("oneshot_hold", lut_cfg_o, 16'h6996);

      // Looping sequence, restart from DONE
      cfg_loop_i = 1'b1; start_i = 1'b1; tick();
      for (int i = 0; i < 5; i++) begin
         event_i = 1'b1; tick();
      end
      check("loop_wrap_idx", 16'(idx_o), 16'h1);

      // stop beats start and event in the same cycle
      event_i = 1'b1; stop_i = 1'b1; start_i = 1'b1; tick();
      check("stop_en", 16'(lut_en_o), 16'h0);
      tick();
      start_i = 1'b1; tick();
      check("restart_cfg", lut_cfg_o, 16'h8000);

      // Write forwarding on the loaded entry, and no change when writing the shown entry
      wr(1, 16'h1234); event_i = 1'b1; tick();
      check("fwd_cfg", lut_cfg_o, 16'h1234);
      wr(1, 16'hABCD); tick();
      check("shown_hold", lut_cfg_o, 16'h1234);
      stop_i = 1'b1; tick();

      // len=0 one-shot, then restart from DONE
      cfg_len_i = 3'd0; cfg_loop_i = 1'b0; start_i = 1'b1; tick();
      event_i = 1'b1; tick();
      check("len0_done", 16'(done_o), 16'h1);
      start_i = 1'b1; tick();
      check("len0_restart_upd", 16'(lut_update_o), 16'h1);
      event_i = 1'b1; tick();

      // len=0 looping reloads entry 0 on every event
      cfg_loop_i = 1'b1; start_i = 1'b1; tick();
      event_i = 1'b1; tick();
      event_i = 1'b1; tick();
      stop_i = 1'b1; tick();

      // Reset mid-sequence clears the pattern file
      cfg_len_i = 3'd3; start_i = 1'b1; tick();
      event_i = 1'b1; tick();
      event_i = 1'b1; tick();
      rstn_i = 1'b0; tick();
      check("midreset_en", 16'(lut_en_o), 16'h0);
      start_i = 1'b1; tick();
      check("cleared_cfg", lut_cfg_o, 16'h0000);

      // Random traffic
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 2) == 0) wr($urandom_range(0, DEPTH - 1), 16'($urandom));
         cfg_len_i  = AW'($urandom_range(0, DEPTH - 1));
         cfg_loop_i = 1'($urandom_range(0, 1));
         start_i    = ($urandom_range(0, 9) == 0);
         stop_i     = ($urandom_range(0, 24) == 0);
         event_i    = ($urandom_range(0, 1) == 0);
         rstn_i     = ($urandom_range(0, 199) != 0);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
